// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures the fetched instruction, PC+4 and valid bit,
// with flush/stall control. Define IFID_STALL_CNT_EN to add a saturating stall counter.
module if_id_register #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ValidIn,
  input  logic [DATA_W-1:0] InstrIn,
  input  logic [DATA_W-1:0] PCPlus4In,
  output logic [DATA_W-1:0] InstrOut,
  output logic [DATA_W-1:0] PCPlus4Out,
  output logic              ValidOut,
  output logic [5:0]        OpcodeOut,
  output logic [4:0]        RsOut,
  output logic [4:0]        RtOut,
  output logic [4:0]        RdOut,
  output logic [5:0]        FunctOut,
  output logic [15:0]       ImmOut
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0]       StallCount
`endif
);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its peers; blocking here would create order-dependent races.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      InstrOut   <= NOP_INSTR;
      PCPlus4Out <= '0;
      ValidOut   <= 1'b0;
    end else if (Flush) begin
      // The squashed slot still carries its PC+4 so link/exception logic sees a sane value.
      InstrOut   <= NOP_INSTR;
      PCPlus4Out <= PCPlus4In;
      ValidOut   <= 1'b0;
    end else if (!Stall) begin
      InstrOut   <= InstrIn;
      PCPlus4Out <= PCPlus4In;
      ValidOut   <= ValidIn;
    end
  end

  // Field decode comes straight off the register, so no input reaches an output combinationally.
  assign OpcodeOut = InstrOut[31:26];
  assign RsOut     = InstrOut[25:21];
  assign RtOut     = InstrOut[20:16];
  assign RdOut     = InstrOut[15:11];
  assign FunctOut  = InstrOut[5:0];
  assign ImmOut    = InstrOut[15:0];

`ifdef IFID_STALL_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCount <= '0;
    end else if (!Flush && Stall && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Directed bench for if_id_register: a reference model pushes expected register
// contents into a scoreboard queue on each drive; entries are popped after the edge.
module tb_if_id_register;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush, ValidIn;
  logic [31:0] InstrIn, PCPlus4In;
  logic [31:0] InstrOut, PCPlus4Out;
  logic        ValidOut;
  logic [5:0]  OpcodeOut, FunctOut;
  logic [4:0]  RsOut, RtOut, RdOut;
  logic [15:0] ImmOut;
`ifdef IFID_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t model;
  exp_t exp_q[$];

  if_id_register #(.DATA_W(32), .NOP_INSTR(32'h0000_0000)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Stall     (Stall),
    .Flush     (Flush),
    .ValidIn   (ValidIn),
    .InstrIn   (InstrIn),
    .PCPlus4In (PCPlus4In),
    .InstrOut  (InstrOut),
    .PCPlus4Out(PCPlus4Out),
    .ValidOut  (ValidOut),
    .OpcodeOut (OpcodeOut),
    .RsOut     (RsOut),
    .RtOut     (RtOut),
    .RdOut     (RdOut),
    .FunctOut  (FunctOut),
    .ImmOut    (ImmOut)
`ifdef IFID_STALL_CNT_EN
    ,
    .StallCount(StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t next_state(input exp_t s, input logic rst, input logic stall,
                                      input logic flush, input logic valid,
                                      input logic [31:0] instr, input logic [31:0] pc);
    exp_t n = s;
    if (rst) begin
      n.instr = 32'h0; n.pc = 32'h0; n.valid = 1'b0; n.cnt = 16'h0;
    end else if (flush) begin
      n.instr = 32'h0; n.pc = pc; n.valid = 1'b0;
    end else if (stall) begin
      if (s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
    end else begin
      n.instr = instr; n.pc = pc; n.valid = valid;
    end
    return n;
  endfunction

  // Drive one cycle at the falling edge, then compare the popped expectation after the rising edge.
  task automatic step(input logic rst, input logic stall, input logic flush, input logic valid,
                      input logic [31:0] instr, input logic [31:0] pc, input bit full_check);
    exp_t e;
    @(negedge Clk);
    Rst = rst; Stall = stall; Flush = flush; ValidIn = valid; InstrIn = instr; PCPlus4In = pc;
    model = next_state(model, rst, stall, flush, valid, instr, pc);
    exp_q.push_back(model);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    if (full_check) begin
      check("instr", InstrOut, e.instr);
      check("pc", PCPlus4Out, e.pc);
      check("valid", {31'b0, ValidOut}, {31'b0, e.valid});
      check("opcode", {26'b0, OpcodeOut}, {26'b0, e.instr[31:26]});
      check("rs", {27'b0, RsOut}, {27'b0, e.instr[25:21]});
      check("rt", {27'b0, RtOut}, {27'b0, e.instr[20:16]});
      check("rd", {27'b0, RdOut}, {27'b0, e.instr[15:11]});
      check("funct", {26'b0, FunctOut}, {26'b0, e.instr[5:0]});
      check("imm", {16'b0, ImmOut}, {16'b0, e.instr[15:0]});
`ifdef IFID_STALL_CNT_EN
      check("stall_cnt", {16'b0, StallCount}, {16'b0, e.cnt});
`endif
    end
  endtask

  initial begin
    model = '0;
    Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; ValidIn = 1'b0;
    InstrIn = 32'h0; PCPlus4In = 32'h0;

    // Reset, including inputs that would otherwise load.
    step(1, 0, 0, 1, 32'h1234_5678, 32'h0000_0100, 1);
    step(1, 1, 1, 1, 32'h1234_5678, 32'h0000_0100, 1);

    // Plain load with fixed field values.
    step(0, 0, 0, 1, 32'h2128_FFFC, 32'h0000_0004, 1);
    check("load_imm", {16'b0, ImmOut}, 32'h0000_FFFC);
    check("load_rs", {27'b0, RsOut}, 32'd9);
    check("load_rt", {27'b0, RtOut}, 32'd8);
    check("load_opcode", {26'b0, OpcodeOut}, 32'h08);
    check("load_valid", {31'b0, ValidOut}, 32'd1);

    // Three-cycle stall while the fetch side keeps changing.
    step(0, 1, 0, 1, 32'hAAAA_0001, 32'h0000_0008, 1);
    step(0, 1, 0, 0, 32'hAAAA_0002, 32'h0000_000C, 1);
    step(0, 1, 0, 1, 32'hAAAA_0003, 32'h0000_0010, 1);
    check("stall_hold", InstrOut, 32'h2128_FFFC);
`ifdef IFID_STALL_CNT_EN
    check("stall_cnt3", {16'b0, StallCount}, 32'd3);
`endif
    // Release loads the value present on the release edge.
    step(0, 0, 0, 1, 32'h8C43_0010, 32'h0000_0014, 1);
    check("release_load", InstrOut, 32'h8C43_0010);

    // Flush wins over stall.
    step(0, 1, 1, 1, 32'h0123_4567, 32'h0000_0018, 1);
    check("flush_instr", InstrOut, 32'h0);
    check("flush_pc", PCPlus4Out, 32'h0000_0018);

    // Bubble: instruction captured verbatim, valid cleared.
    step(0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0000_001C, 1);
    check("bubble_instr", InstrOut, 32'hDEAD_BEEF);
    check("bubble_valid", {31'b0, ValidOut}, 32'd0);

    // Reset on the second stall cycle.
    step(0, 0, 0, 1, 32'h0274_4020, 32'h0000_0020, 1);
    step(0, 1, 0, 1, 32'h0000_0000, 32'h0000_0024, 1);
    step(1, 1, 0, 1, 32'hFFFF_FFFF, 32'h0000_0028, 1);
    check("rst_mid_stall_pc", PCPlus4Out, 32'h0);

    // Resume on the first clean edge, then a lone flush.
    step(0, 0, 0, 1, 32'h3C01_1001, 32'h0000_002C, 1);
    step(0, 0, 1, 1, 32'h3C01_2002, 32'h0000_0030, 1);
    step(0, 0, 0, 1, 32'h0022_1820, 32'h0000_0034, 1);

`ifdef IFID_STALL_CNT_EN
    // Saturation: 65535 stalls reach the ceiling, two more must not wrap.
    step(1, 0, 0, 0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 65535; i++) step(0, 1, 0, 1, i, i, 0);
    check("sat_reach", {16'b0, StallCount}, 32'h0000_FFFF);
    step(0, 1, 0, 1, 32'h5555_5555, 32'h0, 1);
    step(0, 1, 0, 1, 32'h6666_6666, 32'h0, 1);
    check("sat_hold", {16'b0, StallCount}, 32'h0000_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the instruction and PC+4 width.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word loaded on reset or flush.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port Stall, input, 1, from hazard unit; 1 = hold current contents.
REQ-006 SHALL have port Flush, input, 1, from branch/jump resolution; 1 = squash the stage.
REQ-007 SHALL have port ValidIn, input, 1, meaning the IF stage presents a real instruction.
REQ-008 SHALL have port InstrIn, input, DATA_W, the fetched instruction.
REQ-009 SHALL have port PCPlus4In, input, DATA_W, the fetch PC+4.
REQ-010 SHALL have port InstrOut, output, DATA_W, the registered instruction.
REQ-011 SHALL have port PCPlus4Out, output, DATA_W, the registered PC+4.
REQ-012 SHALL have port ValidOut, output, 1, the registered valid bit.
REQ-013 SHALL have port OpcodeOut, output, 6, equal to InstrOut[31:26].
REQ-014 SHALL have port RsOut, output, 5, equal to InstrOut[25:21].
REQ-015 SHALL have port RtOut, output, 5, equal to InstrOut[20:16].
REQ-016 SHALL have port RdOut, output, 5, equal to InstrOut[15:11].
REQ-017 SHALL have port FunctOut, output, 6, equal to InstrOut[5:0].
REQ-018 SHALL have port ImmOut, output, 16, equal to InstrOut[15:0]; it feeds the sign-extension stage directly.
REQ-019 SHALL have port StallCount, output, 16, the stall-cycle counter; present only under IFID_STALL_CNT_EN.

Function
REQ-020 SHALL resolve per-edge priority as Rst > Flush > Stall > load.
REQ-021 SHALL, on load (Flush=0, Stall=0), capture InstrIn, PCPlus4In and ValidIn with 1-cycle latency.
REQ-022 SHALL, on Stall=1 with Flush=0, hold InstrOut, PCPlus4Out and ValidOut unchanged, with inputs ignored.
REQ-023 SHALL, on Flush=1 regardless of Stall, load InstrOut=NOP_INSTR and ValidOut=0, and capture PCPlus4In.
REQ-024 SHALL, when ValidIn=0 on a load, still capture InstrIn verbatim; only ValidOut marks it invalid.
REQ-025 SHALL drive all field outputs (OpcodeOut..ImmOut) combinationally from the InstrOut register, with no extra latency.
REQ-026 SHALL hold a stall for unlimited consecutive cycles with outputs bit-stable throughout.
REQ-027 SHALL load the value present on the edge where Stall deasserts, not the value at stall entry.
REQ-028 SHALL contain no combinational path from any input to any output.

Reset
REQ-029 SHALL, on Rst=1 at a rising edge, set InstrOut=NOP_INSTR, PCPlus4Out=0, ValidOut=0 and StallCount=0.
REQ-030 SHALL let Rst override a Stall or Flush asserted in the same cycle, and take effect mid-stall.
REQ-031 SHALL resume loading on the first edge with Rst=0, Stall=0 and Flush=0.

Configuration
REQ-032 SHALL, with macro IFID_STALL_CNT_EN defined, provide StallCount: it increments by 1 on each edge where Rst=0, Flush=0 and Stall=1, and saturates at 16'hFFFF with no wrap.
REQ-033 SHALL, with IFID_STALL_CNT_EN undefined, omit both the StallCount port and the counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL pass load: InstrIn=32'h2128_FFFC, PCPlus4In=32'h0000_0004, ValidIn=1 -> next cycle InstrOut=32'h2128_FFFC, ImmOut=16'hFFFC, RsOut=9, RtOut=8, OpcodeOut=6'h08, ValidOut=1.
REQ-035 SHALL pass stall: hold Stall=1 for 3 cycles while InstrIn changes -> outputs unchanged; StallCount 0->3 (macro on); on release, next InstrIn loads.
REQ-036 SHALL pass flush-over-stall: Flush=1 and Stall=1 together -> InstrOut=32'h0, ValidOut=0, PCPlus4Out=PCPlus4In, StallCount unchanged.
REQ-037 SHALL pass reset-mid-stall: Rst=1 during the 2nd stall cycle -> InstrOut=0, PCPlus4Out=0, ValidOut=0, StallCount=0 on that edge.
REQ-038 SHALL pass saturation: preload via 65535 stall cycles, then 2 more -> StallCount remains 16'hFFFF.
REQ-039 SHALL pass bubble: ValidIn=0, InstrIn=32'hDEAD_BEEF -> InstrOut=32'hDEAD_BEEF, ValidOut=0.
